// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 32x32->64 shift-and-add multiplier sequencer built around one shared 64-bit CLA adder
module add64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);
    logic [63:0] g, p, c;
    logic [14:0] gg, gp;
    logic [15:0] gc;
    assign g = a & b;
    assign p = a ^ b;
    for (genvar i = 0; i < 16; i++) begin : grp
        if (i < 15) begin : gen_grp_gp
            assign gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                         | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            assign gp[i] = &p[4*i +: 4];
        end
        assign c[4*i]   = gc[i];
        assign c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
        assign c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
        assign c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                        | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
    // group carries ripple between 4-bit lookahead blocks; carry out of bit 63 is never formed
    always_comb begin
        gc[0] = 1'b0;
        for (int k = 0; k < 15; k++) gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    assign sum = p ^ c;
endmodule

module mul_seq_ctrl #(
    parameter int WIDTH     = 32,
    parameter int SKIP_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 op_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;
    logic [63:0] mcand, acc, add_a, add_b, sum;
    logic [31:0] mplier, abs_a, abs_b;
    logic [5:0]  cnt;
    logic        neg, last;
    assign abs_a = (op_signed && op_a[31]) ? ~op_a + 32'd1 : op_a;
    assign abs_b = (op_signed && op_b[31]) ? ~op_b + 32'd1 : op_b;
    assign add_a = (state == FIX) ? ~acc : acc;
    assign add_b = (state == FIX) ? 64'd1 : mcand;
    assign last  = (cnt == 6'd31) || ((SKIP_ZERO != 0) && (mplier[31:1] == 31'd0));
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign product   = acc;
    add64 u_add (.a(add_a), .b(add_b), .sum(sum));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                mcand  <= {32'd0, abs_a};
                mplier <= abs_b;
                neg    <= op_signed & (op_a[31] ^ op_b[31]);
                acc    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                if (mplier[0]) acc <= sum;
                mcand  <= {mcand[62:0], 1'b0};
                mplier <= {1'b0, mplier[31:1]};
                cnt    <= cnt + 6'd1;
            end else if (state == FIX) begin
                acc <= sum;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = in_valid ? CALC : IDLE;
            CALC: state_nxt = last ? (neg ? FIX : DONE) : CALC;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule
